// File: rtl/sockit_spi_pkg.sv
// Shared field positions and types for the SPI task sequencer and command-bus arbiter.
package sockit_spi_pkg;

  localparam int unsigned TSK_IOD   = 31;
  localparam int unsigned TSK_BSY   = 31;
  localparam int unsigned TSK_LEN_W = 31;

  // Command flag positions are counted down from the MSB: bit index is CW - CMD_x.
  localparam int unsigned CMD_SRC  = 1;
  localparam int unsigned CMD_IOD  = 2;
  localparam int unsigned CMD_LST  = 3;
  localparam int unsigned CMD_NB_W = 8;

  typedef enum logic {IDLE, RUN} arb_state_e;

endpackage

// File: rtl/sockit_spi_dma_arb.sv
// Arbitrates the SPI command bus between REG passthrough and DMA tasks,
// splitting each DMA task into word-sized commands.
module sockit_spi_dma_arb
  import sockit_spi_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 32
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          tsk_vld,
  output logic          tsk_rdy,
  input  logic [31:0]   tsk_ctl,
  output logic [31:0]   tsk_sts,
  output logic          tsk_dne,
  input  logic          reg_vld,
  input  logic [CW-1:0] reg_dat,
  output logic          reg_rdy,
  output logic          cmd_vld,
  output logic [CW-1:0] cmd_dat,
  input  logic          cmd_rdy
);

  localparam int unsigned BPW = DW / 8;

  typedef logic [TSK_LEN_W-1:0] len_t;

  // Bytes carried by the next command: the remainder, capped at one word.
  function automatic len_t chunk_nb(input len_t r);
    return (r > len_t'(BPW)) ? len_t'(BPW) : r;
  endfunction

  arb_state_e    state_q, state_d;
  len_t          rem_q, rem_d;
  logic          iod_q, iod_d;
  logic          dne_d;
  len_t          nb;
  logic          lst;
  logic [CW-1:0] dma_dat;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      iod_q   <= 1'b0;
      tsk_dne <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      iod_q   <= iod_d;
      tsk_dne <= dne_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    iod_d   = iod_q;
    dne_d   = 1'b0;
    nb      = chunk_nb(rem_q);
    lst     = (rem_q <= len_t'(BPW));
    dma_dat = '0;
    dma_dat[CW-CMD_SRC] = 1'b1;
    dma_dat[CW-CMD_IOD] = iod_q;
    dma_dat[CW-CMD_LST] = lst;
    dma_dat[CMD_NB_W-1:0] = CMD_NB_W'(nb - len_t'(1));
    tsk_rdy = 1'b0;
    reg_rdy = 1'b0;
    cmd_vld = 1'b0;
    cmd_dat = '0;

    unique case (state_q)
      IDLE: begin
        cmd_vld = reg_vld;
        cmd_dat = reg_dat;
        reg_rdy = cmd_rdy;
        tsk_rdy = ~reg_vld;
        if (tsk_vld && !reg_vld) begin
          iod_d = tsk_ctl[TSK_IOD];
          rem_d = tsk_ctl[TSK_LEN_W-1:0];
          if (tsk_ctl[TSK_LEN_W-1:0] == '0) dne_d = 1'b1;
          else                              state_d = RUN;
        end
      end
      RUN: begin
        cmd_vld = 1'b1;
        cmd_dat = dma_dat;
        if (cmd_rdy) begin
          rem_d = rem_q - nb;
          if (lst) begin
            state_d = IDLE;
            dne_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tsk_sts = {(state_q == RUN), rem_q};
  end

endmodule

// File: tb/tb_sockit_spi_dma_arb.sv
// Directed bench for sockit_spi_dma_arb with a command scoreboard.
module tb_sockit_spi_dma_arb;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        tsk_vld;
  logic        tsk_rdy;
  logic [31:0] tsk_ctl;
  logic [31:0] tsk_sts;
  logic        tsk_dne;
  logic        reg_vld;
  logic [31:0] reg_dat;
  logic        reg_rdy;
  logic        cmd_vld;
  logic [31:0] cmd_dat;
  logic        cmd_rdy;

  int checks = 0;
  int errors = 0;
  int dne_cnt = 0;
  logic [31:0] exp_q[$];

  sockit_spi_dma_arb #(.DW(32), .CW(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .tsk_vld(tsk_vld), .tsk_rdy(tsk_rdy), .tsk_ctl(tsk_ctl),
    .tsk_sts(tsk_sts), .tsk_dne(tsk_dne),
    .reg_vld(reg_vld), .reg_dat(reg_dat), .reg_rdy(reg_rdy),
    .cmd_vld(cmd_vld), .cmd_dat(cmd_dat), .cmd_rdy(cmd_rdy)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every bus transfer is popped against the scoreboard; done pulses are counted.
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1) begin
      if (cmd_vld === 1'b1 && cmd_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_cmd: observed %h expected none", cmd_dat);
        end else begin
          chk("cmd", cmd_dat, exp_q.pop_front());
        end
      end
      if (tsk_dne === 1'b1) dne_cnt++;
    end
  end

  task automatic look();
    @(negedge ACLK);
    #1;
  endtask

  task automatic adv();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESETn = 1'b0;
    tsk_vld = 1'b0;
    tsk_ctl = '0;
    reg_vld = 1'b0;
    reg_dat = '0;
    cmd_rdy = 1'b0;
    look();
    chk("rst_tsk_rdy", 32'(tsk_rdy), 32'd1);
    chk("rst_tsk_sts", tsk_sts, 32'h0);
    chk("rst_cmd_vld", 32'(cmd_vld), 32'd0);
    chk("rst_tsk_dne", 32'(tsk_dne), 32'd0);
    adv();
    ARESETn = 1'b1;
    adv();

    // REG passthrough
    reg_vld = 1'b1; reg_dat = 32'h0000_1234; cmd_rdy = 1'b1;
    exp_q.push_back(32'h0000_1234);
    look();
    chk("pt_cmd_dat", cmd_dat, 32'h0000_1234);
    chk("pt_cmd_vld", 32'(cmd_vld), 32'd1);
    chk("pt_reg_rdy", 32'(reg_rdy), 32'd1);
    chk("pt_tsk_rdy", 32'(tsk_rdy), 32'd0);
    adv();
    reg_vld = 1'b0;

    // Output task, 10 bytes
    tsk_vld = 1'b1; tsk_ctl = 32'h8000_000A;
    exp_q.push_back(32'hC000_0003);
    exp_q.push_back(32'hC000_0003);
    exp_q.push_back(32'hE000_0001);
    look();
    chk("t10_accept_rdy", 32'(tsk_rdy), 32'd1);
    adv();
    tsk_vld = 1'b0;
    look();
    chk("t10_sts0", tsk_sts, 32'h8000_000A);
    chk("t10_reg_rdy", 32'(reg_rdy), 32'd0);
    chk("t10_tsk_rdy", 32'(tsk_rdy), 32'd0);
    adv();
    look();
    chk("t10_sts1", tsk_sts, 32'h8000_0006);
    adv();
    look();
    chk("t10_sts2", tsk_sts, 32'h8000_0002);
    adv();
    look();
    chk("t10_sts3", tsk_sts, 32'h0);
    chk("t10_dne", 32'(tsk_dne), 32'd1);
    chk("t10_rdy_back", 32'(tsk_rdy), 32'd1);
    adv();
    look();
    chk("t10_dne_low", 32'(tsk_dne), 32'd0);
    chk("t10_q_empty", 32'(exp_q.size()), 32'd0);
    adv();

    // Input task, 8 bytes, with a stall and REG held off
    tsk_vld = 1'b1; tsk_ctl = 32'h0000_0008;
    exp_q.push_back(32'h8000_0003);
    exp_q.push_back(32'hA000_0003);
    exp_q.push_back(32'h0000_0055);
    look();
    adv();
    tsk_vld = 1'b0; reg_vld = 1'b1; reg_dat = 32'h0000_0055;
    look();
    chk("bp_sts0", tsk_sts, 32'h8000_0008);
    chk("bp_reg_rdy0", 32'(reg_rdy), 32'd0);
    adv();
    cmd_rdy = 1'b0;
    look();
    chk("bp_stall_dat", cmd_dat, 32'hA000_0003);
    chk("bp_sts1", tsk_sts, 32'h8000_0004);
    chk("bp_reg_rdy1", 32'(reg_rdy), 32'd0);
    adv();
    cmd_rdy = 1'b1;
    look();
    chk("bp_held_dat", cmd_dat, 32'hA000_0003);
    chk("bp_reg_rdy2", 32'(reg_rdy), 32'd0);
    adv();
    look();
    chk("bp_dne", 32'(tsk_dne), 32'd1);
    chk("bp_reg_pass", cmd_dat, 32'h0000_0055);
    adv();
    reg_vld = 1'b0;

    // Zero length
    tsk_vld = 1'b1; tsk_ctl = 32'h8000_0000;
    look();
    adv();
    tsk_vld = 1'b0;
    look();
    chk("z_dne", 32'(tsk_dne), 32'd1);
    chk("z_sts", tsk_sts, 32'h0);
    chk("z_cmd_vld", 32'(cmd_vld), 32'd0);
    adv();
    look();
    chk("z_dne_low", 32'(tsk_dne), 32'd0);
    adv();

    // 5 bytes: remainder of one byte on the last command
    tsk_vld = 1'b1; tsk_ctl = 32'h8000_0005;
    exp_q.push_back(32'hC000_0003);
    exp_q.push_back(32'hE000_0000);
    look();
    adv();
    tsk_vld = 1'b0;
    look(); adv();
    look();
    chk("t5_sts", tsk_sts, 32'h8000_0001);
    adv();
    look();
    chk("t5_dne", 32'(tsk_dne), 32'd1);
    adv();

    // Contention, then reset mid-task
    reg_vld = 1'b1; reg_dat = 32'h0000_ABCD; tsk_vld = 1'b1; tsk_ctl = 32'h8000_0010;
    exp_q.push_back(32'h0000_ABCD);
    look();
    chk("ct_tsk_rdy0", 32'(tsk_rdy), 32'd0);
    chk("ct_reg_rdy", 32'(reg_rdy), 32'd1);
    adv();
    reg_vld = 1'b0;
    exp_q.push_back(32'hC000_0003);
    exp_q.push_back(32'hC000_0003);
    look();
    chk("ct_tsk_rdy1", 32'(tsk_rdy), 32'd1);
    chk("ct_sts_idle", tsk_sts, 32'h0);
    adv();
    tsk_vld = 1'b0;
    look();
    chk("ct_sts0", tsk_sts, 32'h8000_0010);
    adv();
    look();
    chk("ct_sts1", tsk_sts, 32'h8000_000C);
    ARESETn = 1'b0;
    #1;
    chk("rr_sts", tsk_sts, 32'h0);
    chk("rr_cmd_vld", 32'(cmd_vld), 32'd0);
    chk("rr_tsk_rdy", 32'(tsk_rdy), 32'd1);
    chk("rr_dne", 32'(tsk_dne), 32'd0);
    adv();
    adv();
    ARESETn = 1'b1;
    look();
    chk("rr_dne_after", 32'(tsk_dne), 32'd0);
    chk("rr_sts_after", tsk_sts, 32'h0);
    adv();
    look();
    chk("dne_total", 32'(dne_cnt), 32'd4);
    chk("q_final_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sockit_spi_dma_arb.md
# sockit_spi_dma_arb

Task sequencer and command-bus arbiter placed between the register block (REG), the DMA data-stream block and the SPI command bus. When idle, it passes REG commands straight through to the command bus. When REG issues a DMA task, the block takes exclusive ownership of the bus. It then splits the task's byte length into word-sized SPI commands and reports busy status and remaining length back to REG for polling and interrupts.

## Interface
Parameters:
- DW, 32: command data width in bits. Legal values are 8, 16 and 32. BPW = DW/8 bytes per word.
- CW, 32: command word width in bits.

Ports:
- ACLK  in  1: clock. Every register samples on the rising edge.
- ARESETn  in  1: reset, asynchronous, active-low.
- tsk_vld  in  1: task control valid (from REG).
- tsk_rdy  out  1: task control ready (to REG).
- tsk_ctl  in  32: task control word. [31] iod (0 = input, 1 = output); [30:0] len, in bytes.
- tsk_sts  out  32: task status. [31] busy; [30:0] remaining bytes.
- tsk_dne  out  1: one-cycle pulse when a task completes.
- reg_vld  in  1: REG command valid.
- reg_dat  in  CW: REG command word.
- reg_rdy  out  1: REG command ready.
- cmd_vld  out  1: command bus valid.
- cmd_dat  out  CW: command bus word.
- cmd_rdy  in  1: command bus ready.

## Operation
- Handshake rule: a transfer occurs on any cycle where vld&rdy is high. A source must hold vld and its data stable until the transfer occurs.
- States are IDLE and RUN.
- IDLE behaviour:
  - cmd_vld = reg_vld, cmd_dat = reg_dat, reg_rdy = cmd_rdy. These are combinational paths.
  - tsk_rdy = ~reg_vld, so a pending REG command wins over a new task and is never withdrawn.
- Task accept in IDLE (tsk_vld&tsk_rdy):
  - Latch iod and rem = len.
  - If len == 0, stay in IDLE, pulse tsk_dne on the next cycle, and issue no commands.
  - Otherwise go to RUN.
- RUN behaviour:
  - reg_rdy = 0 and tsk_rdy = 0.
  - cmd_vld = 1.
  - cmd_dat carries [CW-1] = 1 (DMA source), [CW-2] = iod and [CW-3] = lst. It also carries [7:0] = nb-1, where nb = min(rem, BPW). All other bits are 0.
  - lst = (rem <= BPW).
- Command accept in RUN:
  - rem <= rem - nb.
  - If lst is set, go to IDLE and assert tsk_dne for exactly one cycle, the cycle after the final transfer.
- tsk_sts:
  - busy = (state == RUN).
  - [30:0] = rem, which is 0 whenever the block is IDLE after a completed task.
- Width rules:
  - rem is 31 bits, unsigned, and never underflows because nb <= rem.
  - The nb comparison uses the full 31 bits.
- Reset values:
  - state = IDLE, rem = 0, iod = 0, tsk_dne = 0.
  - Outputs therefore reset to tsk_rdy = 1 (given reg_vld = 0), tsk_sts = 0 and cmd_vld = reg_vld.
- Reset asserted mid-task: the task is abandoned immediately and no tsk_dne pulse is produced.

## Timing
- Task accepted in cycle N: busy and the first cmd_vld appear in cycle N+1.
- Command throughput is one DMA command per cycle while cmd_rdy = 1.
- Ownership returns to REG in the cycle after the final command transfer, which is the same cycle tsk_dne is high.
- A new task can be accepted in that same cycle. Back-to-back tasks therefore have one dead cycle of bus gap.
- REG passthrough adds zero cycles of latency in IDLE.
- No combinational path exists from cmd_rdy to cmd_vld.

## Structure
- The shared package sockit_spi_pkg holds:
  - the tsk_ctl and tsk_sts field positions (TSK_IOD = 31, TSK_BSY = 31, length slice [30:0]);
  - the command field constants CMD_SRC, CMD_IOD, CMD_LST and CMD_NB slice [7:0];
  - the state enum type {IDLE, RUN}.
- No sub-module is required. The nb/lst chunk computation is a small local function.

## Test plan
- REG passthrough: with the block IDLE, drive reg command 0x0000_1234 while cmd_rdy = 1 → cmd_dat = 0x0000_1234 in the same cycle, reg_rdy = 1, and tsk_rdy = 0 while reg_vld = 1.
- Output task: DW = 32, tsk_ctl = 0x8000_000A → three commands, 0xC000_0003, 0xC000_0003, 0xE000_0001. tsk_sts reads 0x8000_000A, then 0x8000_0006, then 0x8000_0002, then 0; tsk_dne pulses once.
- Backpressure: input task with len = 8 and cmd_rdy toggling 1-0-1 → cmd_dat is held stable during the stall, two commands are issued (0x8000_0003, then 0xA000_0003), and REG is blocked for the whole task.
- Zero length: tsk_ctl = 0x8000_0000 → no cmd_vld from the DMA, busy never set, and tsk_dne pulses the cycle after accept.
- Contention and reset: reg_vld and tsk_vld rise together → the REG command transfers first and the task is accepted the following cycle. Then assert ARESETn = 0 during RUN → state returns to IDLE, tsk_sts = 0 and no tsk_dne pulse occurs.
